// File: rtl/motor_control.sv
// motor_control
//   Combined motor driver front end: an 8-bit PWM channel for a DC motor
//   with dead-time blanking on direction reversal, and a 4-phase wave-drive
//   stepper sequencer advancing at a fixed rate derived from clk.
//
// Parameters:
//   STEP_DIV   clock cycles per stepper step tick (>= 1)
//   DEAD_TIME  extra cycles pwm_dc stays low after a dir_dc change
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   speed_dc     in   [7:0] DC duty command (0 = off, 255 = 255/256 high)
//   dir_dc       in   DC direction command (only triggers dead-time)
//   dir_stepper  in   [1:0] 01 forward, 10 reverse, 00/11 hold
//   pwm_dc       out  registered PWM drive for the DC motor
//   step_out     out  [3:0] registered one-hot stepper phase drive
module motor_control #(
    parameter int STEP_DIV  = 10,
    parameter int DEAD_TIME = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] speed_dc,
    input  logic       dir_dc,
    input  logic [1:0] dir_stepper,
    output logic       pwm_dc,
    output logic [3:0] step_out
);

    localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DEAD_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TIME);

    logic [7:0]        pwm_cnt;
    logic [7:0]        duty_q;
    logic              dir_q;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        phase;

    logic       dead_start;
    logic       tick;
    logic [1:0] next_phase;

    assign dead_start = (dir_dc != dir_q);
    assign tick       = (div_cnt == DIV_LAST);

    always_comb begin
        next_phase = phase;
        unique case (dir_stepper)
            2'b01:   next_phase = phase + 2'd1;
            2'b10:   next_phase = phase - 2'd1;
            default: next_phase = phase;
        endcase
    end

    // ---- PWM and dead-time ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt  <= 8'd0;
            duty_q   <= speed_dc;
            pwm_dc   <= 1'b0;
            dir_q    <= dir_dc;
            dead_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            // Shadow load on the last count so a new duty starts cleanly
            // with the next period.
            if (pwm_cnt == 8'hFF) begin
                duty_q <= speed_dc;
            end
            // The direction edge itself already blanks the output, so the
            // low interval is DEAD_TIME+1 cycles.
            pwm_dc <= (pwm_cnt < duty_q) && (dead_cnt == '0) && !dead_start;
            if (dead_start) begin
                dir_q    <= dir_dc;
                dead_cnt <= DEAD_LOAD;
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - DEAD_W'(1);
            end
        end
    end

    // ---- Stepper sequencer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            phase    <= 2'd0;
            step_out <= 4'b0001;
        end else begin
            if (tick) begin
                div_cnt  <= '0;
                phase    <= next_phase;
                step_out <= 4'b0001 << next_phase;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_motor_control.sv
// tb_motor_control
//   Directed-plus-random bench for motor_control. A behavioural model keeps
//   an edge index since reset, the last direction-change edge and a signed
//   stepper position, and derives the expected outputs arithmetically.
module tb_motor_control;

    localparam int STEP_DIV  = 10;
    localparam int DEAD_TIME = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] speed_dc = 8'd128;
    logic       dir_dc = 1'b0;
    logic [1:0] dir_stepper = 2'b00;
    logic       pwm_dc;
    logic [3:0] step_out;

    motor_control #(
        .STEP_DIV  (STEP_DIV),
        .DEAD_TIME (DEAD_TIME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .speed_dc    (speed_dc),
        .dir_dc      (dir_dc),
        .dir_stepper (dir_stepper),
        .pwm_dc      (pwm_dc),
        .step_out    (step_out)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state
    int       n = 0;            // edges since reset = PWM counter value used at next edge (mod 256)
    int       duty = 0;         // duty in force for the current period
    logic     mdir = 1'b0;      // last direction seen
    int       last_chg = -100;  // edge index of the most recent direction change
    int       pos = 0;          // stepper position, unbounded signed
    logic     exp_pwm = 1'b0;
    logic [3:0] exp_step = 4'b0001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: update the model with the inputs sampled at the edge,
    // then compare outputs 1 time unit later.
    task automatic cyc();
        int ph;
        @(posedge clk);
        if (rst) begin
            n        = 0;
            duty     = speed_dc;
            mdir     = dir_dc;
            last_chg = -100;
            pos      = 0;
            exp_pwm  = 1'b0;
        end else begin
            if (dir_dc != mdir) begin
                mdir     = dir_dc;
                last_chg = n;
            end
            exp_pwm = ((n % 256) < duty) && ((n - last_chg) > DEAD_TIME);
            if ((n % 256) == 255) duty = speed_dc;
            if ((n % STEP_DIV) == STEP_DIV - 1) begin
                if (dir_stepper == 2'b01) pos = pos + 1;
                else if (dir_stepper == 2'b10) pos = pos - 1;
            end
            n++;
        end
        ph = ((pos % 4) + 4) % 4;
        exp_step = 4'b0001 << ph;
        #1;
        check("pwm_dc", 32'(pwm_dc), 32'(exp_pwm));
        check("step_out", 32'(step_out), 32'(exp_step));
    endtask

    // Run until the next edge starts a new PWM period; return highs seen.
    task automatic run_rest(output int hi);
        hi = 0;
        do begin
            cyc();
            hi += int'(pwm_dc);
        end while ((n % 256) != 0);
    endtask

    // Run one full aligned PWM period; return highs seen.
    task automatic run_period(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            hi += int'(pwm_dc);
        end
    endtask

    initial begin
        int  hi;
        bit  found;

        // Reset with speed 128
        rst = 1'b1;
        speed_dc = 8'd128;
        cyc();
        cyc();
        check("rst_pwm", 32'(pwm_dc), 32'd0);
        check("rst_step", 32'(step_out), 32'd1);
        rst = 1'b0;

        run_period(hi);
        check("period1_128", 32'(hi), 32'd128);
        run_period(hi);
        check("period2_128", 32'(hi), 32'd128);

        // Mid-period duty change 128 -> 200
        for (int i = 0; i < 50; i++) cyc();
        speed_dc = 8'd200;
        run_rest(hi);
        check("keep_128_rest", 32'(hi), 32'd78);
        run_period(hi);
        check("period_200", 32'(hi), 32'd200);

        // Extremes
        speed_dc = 8'd0;
        run_rest(hi);
        run_period(hi);
        check("period_0", 32'(hi), 32'd0);
        speed_dc = 8'd255;
        run_rest(hi);
        run_period(hi);
        check("period_255", 32'(hi), 32'd255);

        // Dead-time while high
        speed_dc = 8'd128;
        run_rest(hi);
        for (int i = 0; i < 10; i++) cyc();
        dir_dc = ~dir_dc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("dead_low", 32'(pwm_dc), 32'd0);
        end
        cyc();
        check("dead_resume", 32'(pwm_dc), 32'd1);

        // Restart of blanking on a second toggle
        dir_dc = ~dir_dc;
        cyc();
        cyc();
        dir_dc = ~dir_dc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("dead_restart_low", 32'(pwm_dc), 32'd0);
        end
        cyc();
        check("dead_restart_resume", 32'(pwm_dc), 32'd1);

        // Stepper forward, reverse, hold
        dir_stepper = 2'b01;
        for (int i = 0; i < 50; i++) cyc();
        dir_stepper = 2'b10;
        for (int i = 0; i < 50; i++) cyc();
        dir_stepper = 2'b00;
        for (int i = 0; i < 30; i++) cyc();
        dir_stepper = 2'b11;
        for (int i = 0; i < 30; i++) cyc();

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) speed_dc = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) dir_dc = ~dir_dc;
            if ($urandom_range(0, 6) == 0) dir_stepper = 2'($urandom_range(0, 3));
            cyc();
        end

        // Reset mid-operation: step_out at 0100 during a dead-time
        dir_stepper = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (exp_step == 4'b0100) found = 1'b1;
        end
        check("reach_0100", 32'(found), 32'd1);
        dir_dc = ~dir_dc;
        speed_dc = 8'd128;
        cyc();
        rst = 1'b1;
        cyc();
        check("midrst_pwm", 32'(pwm_dc), 32'd0);
        check("midrst_step", 32'(step_out), 32'd1);
        rst = 1'b0;
        cyc();
        check("midrst_pwm_first", 32'(pwm_dc), 32'd1);
        for (int i = 0; i < 255; i++) cyc();
        run_period(hi);
        check("midrst_period_128", 32'(hi), 32'd128);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
